// File: rtl/avr_clk_ctl_if.sv
// avr_clk_ctl_if: control, button and status signals between the clock-enable controller and its user.
interface avr_clk_ctl_if #(
  parameter int DIV_W  = 23,
  parameter int STEP_W = 8
);
  logic [4:0]        div_sel;
  logic [1:0]        mode;
  logic [STEP_W-1:0] burst_len;
  logic              btn;
  logic              cpu_ce;
  logic              busy;
  logic              step_done;
  logic              btn_db;
  logic [DIV_W-1:0]  div_q;
  modport master (
    output div_sel, mode, burst_len, btn,
    input  cpu_ce, busy, step_done, btn_db, div_q
  );
  modport slave (
    input  div_sel, mode, burst_len, btn,
    output cpu_ce, busy, step_done, btn_db, div_q
  );
endinterface

// File: rtl/avr_clk_ctl.sv
// avr_clk_ctl: CPU clock-enable generator with power-of-two divider and run/halt/step/burst modes.
module avr_clk_ctl #(
  parameter int DIV_W   = 23,
  parameter int DEB_CNT = 50000,
  parameter int STEP_W  = 8
) (
  input logic           clk,
  input logic           rst,
  avr_clk_ctl_if.slave  bus
);
  localparam int DEB_W = DEB_CNT > 1 ? $clog2(DEB_CNT) : 1;
  typedef enum logic {IDLE, ARMED} state_t;
  state_t            state, state_n;
  logic [DIV_W-1:0]  div_q, div_msk;
  logic [4:0]        sel;
  logic              tick;
  logic              btn_m, btn_s, btn_db, btn_db_q, press, deb_hit;
  logic [DEB_W-1:0]  deb;
  logic [1:0]        mode_q;
  logic              mode_chg;
  logic [STEP_W-1:0] rem, rem_n;
  logic              ce, done_n, step_done;
  always_comb begin
    sel      = (32'(bus.div_sel) > DIV_W) ? 5'(DIV_W) : bus.div_sel;
    div_msk  = ~({DIV_W{1'b1}} << sel);
    tick     = (div_q & div_msk) == div_msk;
    deb_hit  = (btn_s != btn_db) && (deb == DEB_W'(DEB_CNT - 1));
    press    = btn_db & ~btn_db_q;
    mode_chg = bus.mode != mode_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      btn_m     <= 1'b0;
      btn_s     <= 1'b0;
      deb       <= '0;
      btn_db    <= 1'b0;
      btn_db_q  <= 1'b0;
      mode_q    <= 2'b00;
      state     <= IDLE;
      rem       <= '0;
      step_done <= 1'b0;
    end else begin
      div_q     <= div_q + DIV_W'(1);
      btn_m     <= bus.btn;
      btn_s     <= btn_m;
      deb       <= (btn_s == btn_db || deb_hit) ? '0 : deb + DEB_W'(1);
      btn_db    <= deb_hit ? btn_s : btn_db;
      btn_db_q  <= btn_db;
      mode_q    <= bus.mode;
      state     <= state_n;
      rem       <= rem_n;
      step_done <= done_n;
    end
  end
  // a mode change always lands in IDLE with no enable, so aborted work never reports done
  always_comb begin
    state_n = state;
    rem_n   = rem;
    ce      = 1'b0;
    done_n  = 1'b0;
    if (mode_chg) begin
      state_n = IDLE;
      rem_n   = '0;
    end else if (bus.mode == 2'b00) begin
      ce = tick;
    end else if (bus.mode[1]) begin
      if (state == IDLE) begin
        if (press && (!bus.mode[0] || bus.burst_len != '0)) begin
          state_n = ARMED;
          rem_n   = bus.mode[0] ? bus.burst_len : STEP_W'(1);
        end
      end else if (tick) begin
        ce    = 1'b1;
        rem_n = rem - STEP_W'(1);
        if (rem == STEP_W'(1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
    end
  end
  assign bus.cpu_ce    = ce & ~rst;
  assign bus.busy      = state == ARMED;
  assign bus.step_done = step_done;
  assign bus.btn_db    = btn_db;
  assign bus.div_q     = div_q;
endmodule

// File: tb/tb_avr_clk_ctl.sv
// tb_avr_clk_ctl: vector table for run/halt/clamp rates plus scoreboarded button, step, burst and abort sequences.
module tb_avr_clk_ctl;
  localparam int DIV_W = 4, DEB_CNT = 4, STEP_W = 8;
  typedef struct {logic ce; logic busy; logic done; logic db;} exp_t;
  typedef struct {logic [1:0] mode; logic [4:0] sel; int cyc; int exp;} vec_t;
  logic clk = 1'b0, rst = 1'b1;
  int pass_n = 0, tot_n = 0, n = 0, ce_cnt = 0, done_cnt = 0, busy_cnt = 0;
  int c0, d0, b0, t;
  logic prev_ce = 1'b0;
  logic [4:0] prev_sel = 5'd0;
  exp_t sb[$];
  exp_t e0;
  vec_t vt[10];
  always #5 clk = ~clk;
  avr_clk_ctl_if #(.DIV_W(DIV_W), .STEP_W(STEP_W)) bus();
  avr_clk_ctl #(.DIV_W(DIV_W), .DEB_CNT(DEB_CNT), .STEP_W(STEP_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  function automatic void chk(string nm, int act, int exp);
    tot_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endfunction
  function automatic int msk(int s);
    return (1 << (s > DIV_W ? DIV_W : s)) - 1;
  endfunction
  function automatic bit tk(int v, int s);
    return (v & msk(s)) == msk(s);
  endfunction
  always @(posedge clk) n <= rst ? 0 : n + 1;
  always @(negedge clk) begin
    chk("div_q", int'(bus.div_q), n % (1 << DIV_W));
    if (bus.cpu_ce) chk("ce_phase", int'(bus.div_q) & msk(int'(bus.div_sel)), msk(int'(bus.div_sel)));
    if (bus.div_sel != 5'd0 && prev_sel != 5'd0) chk("ce_gap", int'(bus.cpu_ce & prev_ce), 0);
    if (sb.size() > 0) begin
      chk("sb_ce", int'(bus.cpu_ce), int'(sb[0].ce));
      chk("sb_busy", int'(bus.busy), int'(sb[0].busy));
      chk("sb_done", int'(bus.step_done), int'(sb[0].done));
      chk("sb_db", int'(bus.btn_db), int'(sb[0].db));
      void'(sb.pop_front());
    end
    ce_cnt   <= ce_cnt + int'(bus.cpu_ce);
    done_cnt <= done_cnt + int'(bus.step_done);
    busy_cnt <= busy_cnt + int'(bus.busy);
    prev_ce  <= bus.cpu_ce;
    prev_sel <= bus.div_sel;
  end
  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic drain();
    int w = 0;
    while (sb.size() > 0 && w < 500) begin
      cyc(1);
      w++;
    end
    chk("sb_drain", sb.size(), 0);
  endtask
  // button goes high now: btn_db follows 6 edges later, press arms on edge 7, enables land on ticks
  task automatic press_seq(input int sel, input int cnt);
    exp_t e;
    bit act = 1'b0, dn = 1'b0;
    int left = cnt, k = 0, n0 = n;
    bus.btn = 1'b1;
    while ((k < 8 || act || dn) && k < 1000) begin
      e.ce   = act && tk(n0 + k, sel);
      e.busy = act;
      e.done = dn;
      e.db   = k >= 6;
      sb.push_back(e);
      dn = 1'b0;
      if (e.ce) begin
        left--;
        if (left == 0) begin
          act = 1'b0;
          dn  = 1'b1;
        end
      end
      if (k == 6 && cnt > 0) act = 1'b1;
      k++;
    end
  endtask
  task automatic release_btn();
    bus.btn = 1'b0;
    cyc(8);
    chk("db_fall", int'(bus.btn_db), 0);
  endtask
  task automatic wait_ce(input int base, input int want);
    int w = 0;
    while (ce_cnt - base < want && w < 300) begin
      cyc(1);
      w++;
    end
    chk("ce_reach", ce_cnt - base, want);
  endtask
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vt = '{'{2'd0, 5'd0, 16, 16}, '{2'd0, 5'd1, 16, 8}, '{2'd0, 5'd2, 16, 4}, '{2'd0, 5'd3, 32, 4},
           '{2'd0, 5'd4, 32, 2}, '{2'd0, 5'd31, 64, 4}, '{2'd0, 5'd9, 48, 3}, '{2'd1, 5'd0, 32, 0},
           '{2'd1, 5'd4, 32, 0}, '{2'd0, 5'd2, 8, 2}};
    bus.mode = 2'd0;
    bus.div_sel = 5'd3;
    bus.burst_len = '0;
    bus.btn = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_ce", int'(bus.cpu_ce), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.step_done), 0);
      chk("rst_db", int'(bus.btn_db), 0);
      chk("rst_div", int'(bus.div_q), 0);
    end
    rst = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      e0 = '{(k % 8) == 7, 1'b0, 1'b0, 1'b0};
      sb.push_back(e0);
    end
    drain();
    for (int i = 0; i < 10; i++) begin
      bus.mode = vt[i].mode;
      bus.div_sel = vt[i].sel;
      cyc(1);
      c0 = ce_cnt;
      b0 = busy_cnt;
      cyc(vt[i].cyc);
      chk($sformatf("vec%0d_ce", i), ce_cnt - c0, vt[i].exp);
      chk($sformatf("vec%0d_busy", i), busy_cnt - b0, 0);
    end
    bus.mode = 2'd1;
    bus.div_sel = 5'd0;
    cyc(1);
    c0 = ce_cnt;
    b0 = busy_cnt;
    repeat (1000) begin
      bus.btn = 1'($urandom_range(0, 1));
      cyc(1);
    end
    chk("halt_ce", ce_cnt - c0, 0);
    chk("halt_busy", busy_cnt - b0, 0);
    bus.btn = 1'b0;
    cyc(10);
    bus.mode = 2'd2;
    bus.div_sel = 5'd2;
    cyc(1);
    c0 = ce_cnt;
    repeat (5) begin
      bus.btn = 1'b1;
      cyc(1);
      bus.btn = 1'b0;
      cyc(3);
      chk("glitch_db", int'(bus.btn_db), 0);
    end
    chk("glitch_ce", ce_cnt - c0, 0);
    d0 = done_cnt;
    press_seq(2, 1);
    drain();
    chk("step_ce", ce_cnt - c0, 1);
    chk("step_done", done_cnt - d0, 1);
    chk("step_busy", int'(bus.busy), 0);
    release_btn();
    bus.mode = 2'd3;
    bus.div_sel = 5'd0;
    bus.burst_len = 8'd5;
    cyc(1);
    c0 = ce_cnt;
    d0 = done_cnt;
    press_seq(0, 5);
    drain();
    chk("burst_ce", ce_cnt - c0, 5);
    chk("burst_done", done_cnt - d0, 1);
    release_btn();
    bus.div_sel = 5'd2;
    c0 = ce_cnt;
    d0 = done_cnt;
    bus.btn = 1'b1;
    cyc(8);
    bus.btn = 1'b0;
    cyc(8);
    bus.btn = 1'b1;
    cyc(30);
    chk("repress_ce", ce_cnt - c0, 5);
    chk("repress_done", done_cnt - d0, 1);
    chk("repress_busy", int'(bus.busy), 0);
    release_btn();
    bus.burst_len = 8'd0;
    bus.div_sel = 5'd0;
    c0 = ce_cnt;
    press_seq(0, 0);
    drain();
    chk("len0_ce", ce_cnt - c0, 0);
    release_btn();
    bus.burst_len = 8'd200;
    bus.div_sel = 5'd1;
    c0 = ce_cnt;
    d0 = done_cnt;
    bus.btn = 1'b1;
    cyc(8);
    bus.btn = 1'b0;
    wait_ce(c0, 10);
    bus.mode = 2'd1;
    cyc(20);
    chk("abort_ce", ce_cnt - c0, 10);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", done_cnt - d0, 0);
    bus.mode = 2'd3;
    cyc(1);
    c0 = ce_cnt;
    d0 = done_cnt;
    bus.btn = 1'b1;
    cyc(8);
    bus.btn = 1'b0;
    wait_ce(c0, 10);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(20);
    chk("rstab_ce", ce_cnt - c0, 10);
    chk("rstab_busy", int'(bus.busy), 0);
    chk("rstab_done", done_cnt - d0, 0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
